int_muldiv_sequencer: RTL and testbench
=======================================

INT_MULDIV_SEQUENCER -- requirements
Module: int_muldiv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_W, default 6, physical destination tag width.
REQ-003 SHALL have parameter MUL_LAT, default 3, fixed multiplier latency in cycles (legal range 1..7).
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 issue_valid  in  1  mul/div instruction issued this cycle.
REQ-007 issue_is_div  in  1  1 = divide/remainder, 0 = multiply.
REQ-008 issue_funct3  in  3  RISC-V M funct3; for divides, bit 1 = 1 selects remainder.
REQ-009 issue_prd  in  TAG_W  destination physical register tag.
REQ-010 issue_rs1_val, issue_rs2_val  in  XLEN each  source operand values.
REQ-011 issue_is_poison  in  1  issued instruction is load-speculative.
REQ-012 load_wake_up_kill  in  1  load misspeculation kill.
REQ-013 branch_miss_flush  in  1  pipeline flush.
REQ-014 mul_start, div_start, div_abort  out  1 each  unit control pulses.
REQ-015 mul_result  in  XLEN  multiplier output; div_done  in  1 and div_result  in  XLEN  divider completion.
REQ-016 wb_req  out  1, wb_prd  out  TAG_W, wb_data  out  XLEN  shared write-port request.
REQ-017 wb_grant  in  1  write-port grant.
REQ-018 muldiv_busy  out  1  unit occupied; issue selector blocks mul/div issue.

Function
REQ-019 SHALL implement states IDLE, SPEC, MUL_WAIT, DIV_WAIT, WB; muldiv_busy SHALL equal (state != IDLE).
REQ-020 In IDLE with issue_valid=1 and branch_miss_flush=0, SHALL latch issue fields and enter SPEC; issue_valid while busy SHALL be ignored.
REQ-021 In SPEC (exactly one cycle), if latched poison=1 and load_wake_up_kill=1, SHALL return to IDLE with no start pulse.
REQ-022 Otherwise in SPEC SHALL assert mul_start or div_start for that single cycle and enter MUL_WAIT or DIV_WAIT.
REQ-023 MUL_WAIT SHALL load a counter with MUL_LAT, decrement each cycle, capture mul_result when the counter reaches 1, and enter WB.
REQ-024 DIV_WAIT SHALL capture div_result on div_done=1 and enter WB; there is no timeout.
REQ-025 WB SHALL drive wb_req=1 with registered wb_prd/wb_data, held stable until wb_grant=1, then go to IDLE on that edge.
REQ-026 branch_miss_flush=1 in any state SHALL force IDLE next cycle, force wb_req=0 that cycle, and take priority over wb_grant, div_done and kill.
REQ-027 Flush in DIV_WAIT, or in SPEC with a latched divide, SHALL assert div_abort for that cycle; start pulses SHALL be suppressed.
REQ-028 Best-case multiply: issue at cycle T -> mul_start at T+1 -> wb_req first high at T+2+MUL_LAT.
REQ-029 mul_start, div_start and div_abort SHALL be low in every cycle not named above.

Reset
REQ-030 On rst: state=IDLE, counter=0, latched fields=0, all outputs=0; rst SHALL override issue, flush and grant.
REQ-031 rst mid-operation SHALL drop the in-flight instruction without div_abort.

Configuration
REQ-032 With MULDIV_DIV_ZERO_BYPASS_EN defined, a divide with issue_rs2_val==0 SHALL skip the divider (no div_start) and go from SPEC directly to WB with result all-ones (quotient ops) or rs1 (remainder ops); kill and flush rules still apply in SPEC.
REQ-033 Without the macro, all divides SHALL use the divider.

Verification
REQ-034 MUL_LAT=3; issue mul at T, prd=5, mul_result=0x1234 at T+4, wb_grant=1 -> mul_start at T+1, wb_req at T+5 with prd=5, data=0x1234; busy low at T+6.
REQ-035 Divide, div_done at T+20 with 0x7, wb_grant withheld 4 cycles -> wb_req high T+21..T+25 with data stable 0x7; IDLE after grant.
REQ-036 Poisoned mul, load_wake_up_kill at T+1 -> no mul_start, busy high only at T+1, no wb_req.
REQ-037 Flush during DIV_WAIT at T+10 -> div_abort=1 at T+10, IDLE at T+11; later div_done ignored.
REQ-038 Flush and wb_grant in the same cycle -> wb_req=0, no writeback, IDLE next cycle.
REQ-039 Bypass enabled: DIVU rs1=0x55, rs2=0 -> no div_start, wb_data=0xFFFFFFFF at T+2; REMU -> 0x55.

Source files
------------

// File: rtl/int_muldiv_sequencer_if.sv
// int_muldiv_sequencer_if: issue, unit-control and writeback signals between the pipeline and the mul/div sequencer
//   master: pipeline/unit side (drives issue, kill/flush, unit results, write-port grant)
//   slave : sequencer side (drives unit start/abort pulses, writeback request, busy)
interface int_muldiv_sequencer_if #(
  parameter int XLEN = 32,
  parameter int TAG_W = 6
);
  logic issue_valid;
  logic issue_is_div;
  logic [2:0] issue_funct3;
  logic [TAG_W-1:0] issue_prd;
  logic [XLEN-1:0] issue_rs1_val;
  logic [XLEN-1:0] issue_rs2_val;
  logic issue_is_poison;
  logic load_wake_up_kill;
  logic branch_miss_flush;
  logic mul_start;
  logic div_start;
  logic div_abort;
  logic [XLEN-1:0] mul_result;
  logic div_done;
  logic [XLEN-1:0] div_result;
  logic wb_req;
  logic [TAG_W-1:0] wb_prd;
  logic [XLEN-1:0] wb_data;
  logic wb_grant;
  logic muldiv_busy;
  modport master (
    output issue_valid, issue_is_div, issue_funct3, issue_prd, issue_rs1_val, issue_rs2_val,
           issue_is_poison, load_wake_up_kill, branch_miss_flush, mul_result, div_done,
           div_result, wb_grant,
    input  mul_start, div_start, div_abort, wb_req, wb_prd, wb_data, muldiv_busy
  );
  modport slave (
    input  issue_valid, issue_is_div, issue_funct3, issue_prd, issue_rs1_val, issue_rs2_val,
           issue_is_poison, load_wake_up_kill, branch_miss_flush, mul_result, div_done,
           div_result, wb_grant,
    output mul_start, div_start, div_abort, wb_req, wb_prd, wb_data, muldiv_busy
  );
endinterface

// File: rtl/int_muldiv_sequencer.sv
// int_muldiv_sequencer: single-entry mul/div sequencer (IDLE -> SPEC -> MUL_WAIT/DIV_WAIT -> WB) with kill, flush and write-port arbitration
//   clk, rst : clock and synchronous active-high reset
//   bus      : int_muldiv_sequencer_if.slave (issue fields, kill/flush, unit control, writeback, busy)
//   MULDIV_DIV_ZERO_BYPASS_EN : when defined, divide-by-zero skips the divider and writes back the architectural result
module int_muldiv_sequencer #(
  parameter int XLEN = 32,
  parameter int TAG_W = 6,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst,
  int_muldiv_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SPEC, MUL_WAIT, DIV_WAIT, WB} state_t;
  localparam logic [2:0] LAT = 3'(MUL_LAT);
  state_t state;
  logic [2:0] cnt;
  logic poison, is_div, kill, byp, go;
  logic [TAG_W-1:0] prd;
  logic [XLEN-1:0] res;
  assign kill = poison && bus.load_wake_up_kill;
`ifdef MULDIV_DIV_ZERO_BYPASS_EN
  logic zero;
  assign byp = is_div && zero;
`else
  assign byp = 1'b0;
`endif
  // Pulses and the write request are combinational so a same-cycle kill or flush can still suppress them;
  // rst gates everything so a reset cycle never aborts or writes back.
  assign go = !rst && !bus.branch_miss_flush && state == SPEC && !kill;
  assign bus.mul_start = go && !is_div;
  assign bus.div_start = go && is_div && !byp;
  assign bus.div_abort = !rst && bus.branch_miss_flush && (state == DIV_WAIT || (state == SPEC && is_div));
  assign bus.wb_req = !rst && !bus.branch_miss_flush && state == WB;
  assign bus.wb_prd = prd;
  assign bus.wb_data = res;
  assign bus.muldiv_busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      poison <= 1'b0;
      is_div <= 1'b0;
      prd <= '0;
      res <= '0;
`ifdef MULDIV_DIV_ZERO_BYPASS_EN
      zero <= 1'b0;
`endif
    end else if (bus.branch_miss_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.issue_valid) begin
          state <= SPEC;
          poison <= bus.issue_is_poison;
          is_div <= bus.issue_is_div;
          prd <= bus.issue_prd;
`ifdef MULDIV_DIV_ZERO_BYPASS_EN
          // Bypass result is staged at issue; a real mul/div result overwrites it later.
          zero <= bus.issue_rs2_val == '0;
          res <= bus.issue_funct3[1] ? bus.issue_rs1_val : '1;
`endif
        end
        SPEC: begin
          state <= kill ? IDLE : !is_div ? MUL_WAIT : byp ? WB : DIV_WAIT;
          cnt <= LAT;
        end
        MUL_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            res <= bus.mul_result;
            state <= WB;
          end
        end
        DIV_WAIT: if (bus.div_done) begin
          res <= bus.div_result;
          state <= WB;
        end
        WB: if (bus.wb_grant) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_muldiv_sequencer.sv
// tb_int_muldiv_sequencer: directed scenarios plus randomized transactions checked against a cycle-timeline model
module tb_int_muldiv_sequencer;
  localparam int XLEN = 32;
  localparam int TAG_W = 6;
  localparam int MUL_LAT = 3;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic o_busy [64];
  logic o_ms [64];
  logic o_ds [64];
  logic o_da [64];
  logic o_wr [64];
  logic [TAG_W-1:0] o_prd [64];
  logic [XLEN-1:0] o_data [64];
  always #5 clk = ~clk;
  int_muldiv_sequencer_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  int_muldiv_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_is_div = 0; bus.issue_funct3 = '0; bus.issue_prd = '0;
    bus.issue_rs1_val = '0; bus.issue_rs2_val = '0; bus.issue_is_poison = 0;
    bus.load_wake_up_kill = 0; bus.branch_miss_flush = 0; bus.mul_result = '0;
    bus.div_done = 0; bus.div_result = '0; bus.wb_grant = 0;
  endtask

  // Drives one instruction issued at cycle 0 and records outputs per cycle. Issue/kill/grant/done
  // noise is injected wherever the sequencer is required to ignore it. Grant is given on the
  // (g+1)-th cycle wb_req is seen, and always asserted in the flush cycle.
  task automatic run_txn(input bit dv, pz, k1, input logic [2:0] f3, input logic [TAG_W-1:0] prd,
                         input logic [XLEN-1:0] r1, r2, mres, dres, input int d, g, fl, output int n);
    int w = 0;
    n = (dv ? d + 1 : 2 + MUL_LAT) + g + 2;
    for (int c = 0; c < n; c++) begin
      bus.issue_valid = (c == 0) || (bus.muldiv_busy && ($urandom % 2 == 1));
      bus.issue_is_div = (c == 0) ? dv : 1'($urandom);
      bus.issue_is_poison = (c == 0) ? pz : 1'($urandom);
      bus.issue_funct3 = (c == 0) ? f3 : 3'($urandom);
      bus.issue_prd = (c == 0) ? prd : TAG_W'($urandom);
      bus.issue_rs1_val = (c == 0) ? r1 : $urandom;
      bus.issue_rs2_val = (c == 0) ? r2 : $urandom;
      bus.load_wake_up_kill = (c == 1) ? k1 : 1'($urandom);
      bus.branch_miss_flush = (c == fl);
      bus.div_done = dv ? (c == d) : 1'($urandom);
      bus.div_result = (dv && c == d) ? dres : $urandom;
      bus.mul_result = (!dv && c == 1 + MUL_LAT) ? mres : $urandom;
      #1;
      if (bus.wb_req) w++;
      bus.wb_grant = bus.wb_req ? (w == g + 1) : (c == fl || $urandom % 2 == 1);
      @(negedge clk);
      o_busy[c] = bus.muldiv_busy; o_ms[c] = bus.mul_start; o_ds[c] = bus.div_start;
      o_da[c] = bus.div_abort; o_wr[c] = bus.wb_req; o_prd[c] = bus.wb_prd; o_data[c] = bus.wb_data;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.muldiv_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.muldiv_busy); end
    checks++; if ({bus.wb_req, bus.mul_start, bus.div_start, bus.div_abort} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {bus.wb_req, bus.mul_start, bus.div_start, bus.div_abort}); end
    checks++; if ({bus.wb_prd, bus.wb_data} !== '0) begin errors++; $display("FAIL reset_wb got %h/%h exp 0/0", bus.wb_prd, bus.wb_data); end
    @(posedge clk); #1;
    rst = 0;
    bus.issue_valid = 1; bus.issue_is_div = 1; bus.issue_prd = 9;
    @(posedge clk); #1;
    bus.issue_valid = 0;
    @(posedge clk); #1;
    rst = 1; bus.branch_miss_flush = 1; bus.wb_grant = 1; bus.issue_valid = 1; bus.div_done = 1; bus.div_result = 32'hABCD;
    @(negedge clk);
    checks++; if (bus.div_abort !== 1'b0) begin errors++; $display("FAIL reset_no_abort got %b exp 0", bus.div_abort); end
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.muldiv_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b exp 0", bus.muldiv_busy); end
    checks++; if ({bus.wb_prd, bus.wb_data} !== '0) begin errors++; $display("FAIL reset_mid_wb got %h/%h exp 0/0", bus.wb_prd, bus.wb_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int n;
    run_txn(0, 0, 0, 3'd0, 6'd5, 32'd3, 32'd4, 32'h1234, 32'h0, 0, 0, -1, n);
    checks++; if ({o_ms[0], o_ms[1], o_ms[2]} !== 3'b010) begin errors++; $display("FAIL mul_start got %b exp 010", {o_ms[0], o_ms[1], o_ms[2]}); end
    checks++; if ({o_wr[4], o_wr[5]} !== 2'b01) begin errors++; $display("FAIL mul_wb_req_first got %b exp 01", {o_wr[4], o_wr[5]}); end
    checks++; if (o_prd[5] !== 6'd5) begin errors++; $display("FAIL mul_wb_prd got %0d exp 5", o_prd[5]); end
    checks++; if (o_data[5] !== 32'h1234) begin errors++; $display("FAIL mul_wb_data got %h exp 00001234", o_data[5]); end
    checks++; if ({o_busy[5], o_busy[6]} !== 2'b10) begin errors++; $display("FAIL mul_busy_end got %b exp 10", {o_busy[5], o_busy[6]}); end
  endtask

  task automatic test_div_grant_stall();
    int n;
    run_txn(1, 0, 0, 3'b101, 6'd12, 32'd50, 32'd7, 32'h0, 32'h7, 20, 4, -1, n);
    checks++; if (o_ds[1] !== 1'b1) begin errors++; $display("FAIL div_start got %b exp 1", o_ds[1]); end
    checks++; if (o_wr[20] !== 1'b0) begin errors++; $display("FAIL div_wb_early got %b exp 0", o_wr[20]); end
    for (int c = 21; c <= 25; c++) begin
      checks++; if (o_wr[c] !== 1'b1 || o_data[c] !== 32'h7 || o_prd[c] !== 6'd12) begin errors++; $display("FAIL div_wb_hold c=%0d got %b/%h/%0d exp 1/00000007/12", c, o_wr[c], o_data[c], o_prd[c]); end
    end
    checks++; if (o_busy[26] !== 1'b0) begin errors++; $display("FAIL div_idle_after_grant got %b exp 0", o_busy[26]); end
  endtask

  task automatic test_kill();
    int n;
    bit any;
    run_txn(0, 1, 1, 3'd0, 6'd3, 32'd1, 32'd2, 32'h55, 32'h0, 0, 0, -1, n);
    any = 0;
    for (int c = 0; c < n; c++) any |= o_wr[c] | o_ms[c];
    checks++; if ({o_busy[0], o_busy[1], o_busy[2]} !== 3'b010) begin errors++; $display("FAIL kill_busy got %b exp 010", {o_busy[0], o_busy[1], o_busy[2]}); end
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL kill_no_start_wb got %b exp 0", any); end
  endtask

  task automatic test_flush_div();
    int n;
    bit any;
    run_txn(1, 0, 0, 3'b100, 6'd7, 32'd9, 32'd3, 32'h0, 32'h3, 15, 0, 10, n);
    checks++; if ({o_da[9], o_da[10], o_da[11]} !== 3'b010) begin errors++; $display("FAIL flush_div_abort got %b exp 010", {o_da[9], o_da[10], o_da[11]}); end
    any = 0;
    for (int c = 11; c < n; c++) any |= o_busy[c] | o_wr[c];
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL flush_div_idle got %b exp 0", any); end
  endtask

  task automatic test_flush_grant();
    int n;
    run_txn(0, 0, 0, 3'd0, 6'd21, 32'd1, 32'd1, 32'hBEEF, 32'h0, 0, 2, 6, n);
    checks++; if ({o_wr[5], o_wr[6], o_wr[7]} !== 3'b100) begin errors++; $display("FAIL flush_grant_req got %b exp 100", {o_wr[5], o_wr[6], o_wr[7]}); end
    checks++; if ({o_busy[6], o_busy[7]} !== 2'b10) begin errors++; $display("FAIL flush_grant_idle got %b exp 10", {o_busy[6], o_busy[7]}); end
  endtask

`ifdef MULDIV_DIV_ZERO_BYPASS_EN
  task automatic test_bypass();
    int n;
    run_txn(1, 0, 0, 3'b101, 6'd4, 32'h55, 32'h0, 32'h0, 32'h1, 5, 0, -1, n);
    checks++; if (o_ds[1] !== 1'b0) begin errors++; $display("FAIL bypass_divu_start got %b exp 0", o_ds[1]); end
    checks++; if (o_wr[2] !== 1'b1 || o_data[2] !== 32'hFFFFFFFF) begin errors++; $display("FAIL bypass_divu got %b/%h exp 1/ffffffff", o_wr[2], o_data[2]); end
    run_txn(1, 0, 0, 3'b111, 6'd4, 32'h55, 32'h0, 32'h0, 32'h1, 5, 0, -1, n);
    checks++; if (o_wr[2] !== 1'b1 || o_data[2] !== 32'h55) begin errors++; $display("FAIL bypass_remu got %b/%h exp 1/00000055", o_wr[2], o_data[2]); end
  endtask
`endif

  // Timeline model: each instruction occupies cycles 1..last, where last is the kill cycle,
  // the flush cycle, or the grant cycle; writeback window starts at SPEC+1+latency.
  task automatic test_random();
    bit dv, pz, k1, killed, byp, eb, ems, eds, eda, ewr;
    logic [2:0] f3;
    logic [TAG_W-1:0] prd;
    logic [XLEN-1:0] r1, r2, mres, dres, ed;
    int d, g, fl, wf, wl, last, n;
    for (int t = 0; t < 200; t++) begin
      dv = 1'($urandom); pz = 1'($urandom); k1 = 1'($urandom);
      f3 = 3'($urandom); prd = TAG_W'($urandom);
      r1 = $urandom; r2 = ($urandom % 4 == 0) ? '0 : $urandom;
      mres = $urandom; dres = $urandom;
      d = $urandom_range(2, 12); g = $urandom_range(0, 3);
`ifdef MULDIV_DIV_ZERO_BYPASS_EN
      byp = dv && r2 == 0;
`else
      byp = 0;
`endif
      wf = dv ? (byp ? 2 : d + 1) : 2 + MUL_LAT;
      wl = wf + g;
      fl = ($urandom % 3 == 0) ? $urandom_range(0, wl) : -1;
      killed = pz && k1 && fl != 1;
      last = (fl == 0) ? 0 : killed ? 1 : (fl >= 1 && fl <= wl) ? fl : wl;
      ed = dv ? (byp ? (f3[1] ? r1 : '1) : dres) : mres;
      run_txn(dv, pz, k1, f3, prd, r1, r2, mres, dres, d, g, fl, n);
      for (int c = 0; c < n; c++) begin
        eb = c >= 1 && c <= last;
        ems = c == 1 && eb && !dv && !killed && fl != 1;
        eds = c == 1 && eb && dv && !byp && !killed && fl != 1;
        eda = c == fl && eb && dv && c < wf;
        ewr = eb && !killed && c >= wf && c != fl;
        checks++; if (o_busy[c] !== eb) begin errors++; $display("FAIL rnd_busy t=%0d c=%0d got %b exp %b", t, c, o_busy[c], eb); end
        checks++; if ({o_ms[c], o_ds[c], o_da[c]} !== {ems, eds, eda}) begin errors++; $display("FAIL rnd_pulses t=%0d c=%0d got %b exp %b", t, c, {o_ms[c], o_ds[c], o_da[c]}, {ems, eds, eda}); end
        checks++; if (o_wr[c] !== ewr) begin errors++; $display("FAIL rnd_wb_req t=%0d c=%0d got %b exp %b", t, c, o_wr[c], ewr); end
        if (ewr) begin
          checks++; if (o_prd[c] !== prd || o_data[c] !== ed) begin errors++; $display("FAIL rnd_wb_data t=%0d c=%0d got %0d/%h exp %0d/%h", t, c, o_prd[c], o_data[c], prd, ed); end
        end
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_mul();
    test_div_grant_stall();
    test_kill();
    test_flush_div();
    test_flush_grant();
`ifdef MULDIV_DIV_ZERO_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
